fetch_stage: RTL and testbench

- Instruction-fetch front end of the RV64 core. Owns the 64-bit program counter, drives the address into the combinational instruction memory, and captures the returned 32-bit word into the IF/ID pipeline register.
- Handles sequential fetch, branch redirect with wrong-path squash, decode-requested stalls, and halting when fetch runs past the end of the program image.
- Sits between the branch-resolution logic (upstream control) and the decode stage (downstream consumer of if_id_*).

---
 rtl/fetch_stage.sv | 98 +++++++++
 tb/tb_fetch_stage.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch front end: owns the program counter, drives the instruction
// memory address and registers the returned word into the IF/ID pipeline stage.
module fetch_stage #(
  parameter logic [63:0] RESET_PC  = 64'd0,
  parameter int          MEM_BYTES = 160,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [63:0] branch_target,
  output logic [63:0] inst_address,
  input  logic [31:0] instruction,
  output logic [63:0] if_id_pc,
  output logic [31:0] if_id_instr,
  output logic        if_id_valid,
  output logic        halted,
  output logic        fetch_fault,
  output logic [31:0] fetch_count
);

  localparam logic [0:0]  RUN       = 1'b0;
  localparam logic [0:0]  HALT      = 1'b1;
  localparam logic [63:0] LAST_ADDR = 64'(MEM_BYTES - 4);

  logic [0:0]  state;
  logic [63:0] pc;
  logic [63:0] pc_plus4;
  logic        target_ok;
  logic        pc_ok;

  // IF/ID handshake: if_id_valid marks a real instruction in the register;
  // decode has no ready line, it holds the stage by raising stall (stall is the
  // inverse of ready), and a redirect drops whatever is in flight regardless.
  assign inst_address = pc;
  assign halted       = (state == HALT);
  assign pc_plus4     = pc + 64'd4;
  assign target_ok    = (branch_target[1:0] == 2'b00) && (branch_target <= LAST_ADDR);
  assign pc_ok        = (pc <= LAST_ADDR);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= RUN;
      pc          <= RESET_PC;
      if_id_pc    <= 64'd0;
      if_id_instr <= NOP_INSTR;
      if_id_valid <= 1'b0;
      fetch_fault <= 1'b0;
      fetch_count <= 32'd0;
    end else begin
      case (state)
        RUN: begin
          if (branch_taken) begin
            if_id_valid <= 1'b0;
            if_id_instr <= NOP_INSTR;
            if_id_pc    <= pc;
            if (target_ok) begin
              pc          <= branch_target;
              fetch_fault <= 1'b0;
            end else begin
              fetch_fault <= 1'b1;
              state       <= HALT;
            end
          end else if (!stall) begin
            if (pc_ok) begin
              if_id_pc    <= pc;
              if_id_instr <= instruction;
              if_id_valid <= 1'b1;
              pc          <= pc_plus4;
              if (fetch_count != 32'hFFFF_FFFF) fetch_count <= fetch_count + 32'd1;
            end else begin
              // Ran off the end of the image: park until a redirect arrives.
              if_id_valid <= 1'b0;
              if_id_instr <= NOP_INSTR;
              state       <= HALT;
            end
          end
        end
        HALT: begin
          if_id_valid <= 1'b0;
          if_id_instr <= NOP_INSTR;
          if (branch_taken) begin
            if (target_ok) begin
              pc          <= branch_target;
              fetch_fault <= 1'b0;
              state       <= RUN;
            end else begin
              fetch_fault <= 1'b1;
            end
          end
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a word-array instruction memory feeds the DUT,
// expected IF/ID contents go through a queue and are checked as they emerge.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        branch_taken;
  logic [63:0] branch_target;
  logic [63:0] inst_address;
  logic [31:0] instruction;
  logic [63:0] if_id_pc;
  logic [31:0] if_id_instr;
  logic        if_id_valid;
  logic        halted;
  logic        fetch_fault;
  logic [31:0] fetch_count;

  logic [31:0] mem [0:39];
  logic [96:0] exp_q [$];
  int          total = 0;
  int          bad = 0;
  logic [63:0] exp_pc;
  logic [31:0] exp_cnt;

  fetch_stage dut (
    .clk(clk), .reset(reset), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .inst_address(inst_address),
    .instruction(instruction), .if_id_pc(if_id_pc), .if_id_instr(if_id_instr),
    .if_id_valid(if_id_valid), .halted(halted), .fetch_fault(fetch_fault),
    .fetch_count(fetch_count)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    if (a <= 64'd156 && a[1:0] == 2'b00) return mem[a[7:2]];
    return 32'h0;
  endfunction

  always_comb instruction = mem_word(inst_address);

  task automatic chk(input string tag, input logic [96:0] obs, input logic [96:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pop_chk(input string tag);
    logic [96:0] e;
    if (exp_q.size() == 0) begin
      total++; bad++;
      $error("FAIL %s: got empty queue expected entry", tag);
    end else begin
      e = exp_q.pop_front();
      chk(tag, {if_id_pc, if_id_instr, if_id_valid}, e);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_pc"}, 97'(inst_address), 97'(64'd0));
    chk({tag, "_ifid"}, {if_id_pc, if_id_instr, if_id_valid}, {64'd0, NOP, 1'b0});
    chk({tag, "_flags"}, 97'({halted, fetch_fault}), 97'(2'b00));
    chk({tag, "_cnt"}, 97'(fetch_count), 97'(32'd0));
  endtask

  // Driver: one sequential fetch of the word at exp_pc.
  task automatic fetch_one(input string tag);
    exp_q.push_back({exp_pc, mem_word(exp_pc), 1'b1});
    step();
    exp_pc  = exp_pc + 64'd4;
    exp_cnt = exp_cnt + 32'd1;
    pop_chk(tag);
    chk({tag, "_pc"}, 97'(inst_address), 97'(exp_pc));
    chk({tag, "_cnt"}, 97'(fetch_count), 97'(exp_cnt));
  endtask

  task automatic redirect(input logic [63:0] tgt, input logic with_stall);
    branch_taken  = 1'b1;
    branch_target = tgt;
    stall         = with_stall;
    step();
    branch_taken  = 1'b0;
    stall         = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 40; i++) mem[i] = $urandom_range(32'h7FFF_FFFF, 32'h100);
    mem[0] = 32'h0040_0593;
    mem[1] = 32'h0000_0313;
    mem[4] = 32'h08B3_0863;

    reset = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_target = 64'd0;
    exp_pc = 64'd0; exp_cnt = 32'd0;
    repeat (2) step();
    check_reset_vals("reset");
    @(negedge clk);
    reset = 1'b1;

    // Sequential fetch
    fetch_one("seq0");
    chk("seq0_instr", 97'(if_id_instr), 97'(32'h0040_0593));
    fetch_one("seq1");
    chk("seq1_instr", 97'(if_id_instr), 97'(32'h0000_0313));

    // Stall at pc=8
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_pc", 97'(inst_address), 97'(64'd8));
      chk("stall_ifid", {if_id_pc, if_id_instr, if_id_valid}, {64'd4, mem[1], 1'b1});
      chk("stall_cnt", 97'(fetch_count), 97'(32'd2));
    end
    stall = 1'b0;
    fetch_one("post_stall");
    fetch_one("seq3");
    fetch_one("seq4");

    // Redirect at pc=20 with simultaneous stall
    exp_q.push_back({64'd20, NOP, 1'b0});
    redirect(64'd16, 1'b1);
    pop_chk("redir_squash");
    chk("redir_pc", 97'(inst_address), 97'(64'd16));
    chk("redir_cnt", 97'(fetch_count), 97'(exp_cnt));
    exp_pc = 64'd16;
    fetch_one("redir_tgt");
    chk("redir_instr", 97'(if_id_instr), 97'(32'h08B3_0863));

    // Run to end of image
    while (exp_pc != 64'd160) fetch_one("run");
    exp_q.push_back({64'd156, NOP, 1'b0});
    step();
    pop_chk("end_squash");
    chk("end_halt", 97'({halted, fetch_fault}), 97'(2'b10));
    chk("end_pc", 97'(inst_address), 97'(64'd160));
    stall = 1'b1;
    step();
    stall = 1'b0;
    chk("halt_hold", 97'({halted, inst_address}), {33'd0, 1'b1, 64'd160});
    redirect(64'd0, 1'b0);
    chk("wake_flags", 97'({halted, fetch_fault}), 97'(2'b00));
    chk("wake_pc", 97'(inst_address), 97'(64'd0));
    chk("wake_valid", 97'(if_id_valid), 97'(1'b0));
    exp_pc = 64'd0;
    fetch_one("wake_fetch");
    chk("wake_instr", 97'(if_id_instr), 97'(32'h0040_0593));

    // Illegal targets: misaligned from RUN, out of range from HALT, then recover
    redirect(64'h6, 1'b0);
    chk("mis_flags", 97'({halted, fetch_fault}), 97'(2'b11));
    chk("mis_pc", 97'(inst_address), 97'(64'd4));
    chk("mis_ifid", {if_id_pc, if_id_instr, if_id_valid}, {64'd4, NOP, 1'b0});
    redirect(64'd164, 1'b0);
    chk("oor_flags", 97'({halted, fetch_fault}), 97'(2'b11));
    chk("oor_pc", 97'(inst_address), 97'(64'd4));
    redirect(64'd0, 1'b0);
    chk("fix_flags", 97'({halted, fetch_fault}), 97'(2'b00));
    chk("fix_pc", 97'(inst_address), 97'(64'd0));
    exp_pc = 64'd0;
    fetch_one("fix_fetch0");
    fetch_one("fix_fetch1");

    // Asynchronous reset between edges
    @(negedge clk);
    #1 reset = 1'b0;
    #1 check_reset_vals("async");
    #1 reset = 1'b1;
    exp_pc = 64'd0; exp_cnt = 32'd0;
    fetch_one("after_rst");
    chk("after_rst_instr", 97'(if_id_instr), 97'(32'h0040_0593));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
